// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between N bus requesters and the round-robin bus arbiter.
// The arbiter connects through the slave modport; the requester side uses master.
interface bus_arbiter_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) ();
    localparam int unsigned HW = 4;

    logic [N-1:0]  arb_req;
    logic [N-1:0]  arb_grant;
    logic          grant_valid;
    logic [IW-1:0] grant_id;
    logic [HW-1:0] hold_cnt;

    modport master (
        output arb_req,
        input  arb_grant,
        input  grant_valid,
        input  grant_id,
        input  hold_cnt
    );

    modport slave (
        input  arb_req,
        output arb_grant,
        output grant_valid,
        output grant_id,
        output hold_cnt
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a per-owner hold limit; a continuously requesting
// owner is preempted after MAXHOLD cycles when anyone else is waiting.
module bus_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned MAXHOLD = 4,
    parameter int unsigned IW      = 2
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);
    localparam int unsigned HW = 4;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAXHOLD);
    localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [IW-1:0] last;
    logic [IW-1:0] last_n;
    logic [N-1:0]  grant_n;
    logic          valid_n;
    logic [IW-1:0] id_n;
    logic [HW-1:0] hold_n;

    logic [IW-1:0] win_c;
    logic          owner_req_c;
    logic          others_c;

    // Rotating priority search starting just above the most recent owner.
    always_comb begin : pick
        logic          found;
        logic [IW-1:0] cand;
        found = 1'b0;
        cand  = '0;
        win_c = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IW'((32'(last) + i) % N);
            if (!found && bus.arb_req[cand]) begin
                found = 1'b1;
                win_c = cand;
            end
        end
    end

    // In IDLE arb_grant is zero, so others_c reduces to "any request".
    assign owner_req_c = bus.arb_req[bus.grant_id] && (state == OWN);
    assign others_c    = |(bus.arb_req & ~bus.arb_grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            last            <= LAST_RST;
            bus.arb_grant   <= '0;
            bus.grant_valid <= 1'b0;
            bus.grant_id    <= '0;
            bus.hold_cnt    <= '0;
        end else begin
            state           <= state_n;
            last            <= last_n;
            bus.arb_grant   <= grant_n;
            bus.grant_valid <= valid_n;
            bus.grant_id    <= id_n;
            bus.hold_cnt    <= hold_n;
        end
    end

    always_comb begin
        state_n = state;
        last_n  = last;
        grant_n = bus.arb_grant;
        id_n    = bus.grant_id;
        hold_n  = bus.hold_cnt;

        unique case (state)
            IDLE: begin
                if (|bus.arb_req) begin
                    state_n = OWN;
                    grant_n = N'(1) << win_c;
                    id_n    = win_c;
                    hold_n  = HW'(1);
                    last_n  = win_c;
                end
            end
            OWN: begin
                if (!owner_req_c) begin
                    if (others_c) begin
                        grant_n = N'(1) << win_c;
                        id_n    = win_c;
                        hold_n  = HW'(1);
                        last_n  = win_c;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                        id_n    = '0;
                        hold_n  = '0;
                    end
                end else if (bus.hold_cnt < HOLD_MAX) begin
                    hold_n = bus.hold_cnt + HW'(1);
                end else if (others_c) begin
                    // Owner is visited last by the wrap search, so it loses the tie.
                    grant_n = N'(1) << win_c;
                    id_n    = win_c;
                    hold_n  = HW'(1);
                    last_n  = win_c;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                id_n    = '0;
                hold_n  = '0;
            end
        endcase

        valid_n = (state_n == OWN);
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (N=4, MAXHOLD=4): expected outputs are queued
// when each request pattern is driven and checked one cycle later.
module tb_bus_arbiter;
    typedef struct {
        logic [3:0] grant;
        logic       valid;
        logic [1:0] id;
        logic [3:0] hold;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    int   nvec = 0;
    int   nerr = 0;

    bus_arbiter_if #(.N(4), .IW(2)) bus ();

    bus_arbiter #(.N(4), .MAXHOLD(4), .IW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [3:0] g, input logic [1:0] id,
                        input logic [3:0] h, input string tag);
        exp_t e;
        e.grant = g;
        e.valid = (g != 4'b0000);
        e.id    = id;
        e.hold  = h;
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $error("FAIL scoreboard_empty got 0 entries want 1");
        end else begin
            e = exp_q.pop_front();
            nvec++;
            assert (bus.arb_grant === e.grant) else begin
                nerr++;
                $error("FAIL %s arb_grant got %b want %b", e.tag, bus.arb_grant, e.grant);
            end
            nvec++;
            assert (bus.grant_valid === e.valid) else begin
                nerr++;
                $error("FAIL %s grant_valid got %b want %b", e.tag, bus.grant_valid, e.valid);
            end
            nvec++;
            assert (bus.grant_id === e.id) else begin
                nerr++;
                $error("FAIL %s grant_id got %0d want %0d", e.tag, bus.grant_id, e.id);
            end
            nvec++;
            assert (bus.hold_cnt === e.hold) else begin
                nerr++;
                $error("FAIL %s hold_cnt got %0d want %0d", e.tag, bus.hold_cnt, e.hold);
            end
            nvec++;
            assert ($onehot0(bus.arb_grant)) else begin
                nerr++;
                $error("FAIL %s onehot got %b want at most one bit", e.tag, bus.arb_grant);
            end
        end
    endtask

    // Drive a pattern before the edge, expect its result after the edge.
    task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] id,
                        input logic [3:0] h, input string tag);
        @(negedge clk);
        bus.arb_req = r;
        push(g, id, h, tag);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        logic [3:0] g;
        int         o;

        rst         = 1'b1;
        bus.arb_req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        push(4'b0000, 2'd0, 4'd0, "reset");
        pop_check();
        rst = 1'b0;

        // Two requesters: hold limit then preemption, then back.
        step(4'b1010, 4'b0010, 2'd1, 4'd1, "pre_a1");
        step(4'b1010, 4'b0010, 2'd1, 4'd2, "pre_a2");
        step(4'b1010, 4'b0010, 2'd1, 4'd3, "pre_a3");
        step(4'b1010, 4'b0010, 2'd1, 4'd4, "pre_a4");
        step(4'b1010, 4'b1000, 2'd3, 4'd1, "pre_b1");
        step(4'b1010, 4'b1000, 2'd3, 4'd2, "pre_b2");
        step(4'b1010, 4'b1000, 2'd3, 4'd3, "pre_b3");
        step(4'b1010, 4'b1000, 2'd3, 4'd4, "pre_b4");
        step(4'b1010, 4'b0010, 2'd1, 4'd1, "pre_c1");
        step(4'b0000, 4'b0000, 2'd0, 4'd0, "pre_idle");

        // Short single request then release to idle.
        step(4'b0100, 4'b0100, 2'd2, 4'd1, "short1");
        step(4'b0100, 4'b0100, 2'd2, 4'd2, "short2");
        step(4'b0100, 4'b0100, 2'd2, 4'd3, "short3");
        step(4'b0000, 4'b0000, 2'd0, 4'd0, "short_idle");

        // Request pulse that is gone before the sampling edge.
        @(negedge clk);
        bus.arb_req = 4'b0010;
        #2;
        bus.arb_req = 4'b0000;
        push(4'b0000, 2'd0, 4'd0, "glitch");
        @(posedge clk);
        #1;
        pop_check();

        // Restore reset priority before the full-load rotation.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        push(4'b0000, 2'd0, 4'd0, "reset2");
        pop_check();
        rst = 1'b0;

        for (int c = 0; c < 20; c++) begin
            o = (c / 4) % 4;
            g = 4'b0001 << o;
            step(4'b1111, g, 2'(o), 4'(c % 4 + 1), "rotate");
        end
        step(4'b0000, 4'b0000, 2'd0, 4'd0, "rotate_idle");

        // Lone requester keeps the grant and the count saturates.
        for (int c = 0; c < 10; c++) begin
            step(4'b1000, 4'b1000, 2'd3, (c < 4) ? 4'(c + 1) : 4'd4, "saturate");
        end
        step(4'b0000, 4'b0000, 2'd0, 4'd0, "sat_idle");

        // Owner drops with others waiting: direct handoff via wrap search.
        step(4'b0010, 4'b0010, 2'd1, 4'd1, "drop_a");
        step(4'b0111, 4'b0010, 2'd1, 4'd2, "drop_b");
        step(4'b0101, 4'b0100, 2'd2, 4'd1, "drop_switch");
        step(4'b0101, 4'b0100, 2'd2, 4'd2, "drop_keep");

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst = 1'b1;
        #1;
        push(4'b0000, 2'd0, 4'd0, "async_rst");
        pop_check();
        @(posedge clk);
        #1;
        rst = 1'b0;

        step(4'b0101, 4'b0001, 2'd0, 4'd1, "post_rst1");
        step(4'b0101, 4'b0001, 2'd0, 4'd2, "post_rst2");
        step(4'b0101, 4'b0001, 2'd0, 4'd3, "post_rst3");
        step(4'b0101, 4'b0001, 2'd0, 4'd4, "post_rst4");
        step(4'b0101, 4'b0100, 2'd2, 4'd1, "post_rst_pre");
        step(4'b0000, 4'b0000, 2'd0, 4'd0, "final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
